instr_loader: RTL and testbench

Program-download sequencer for the instruction memory. It accepts a byte stream from the host link over a valid/ready handshake and packs it into little-endian 32-bit words. Each word is written to the instruction RAM at consecutive byte addresses (step 4). On the STOP word it signals completion so the top-level state machine can enter RUN. It sits between the host byte interface and the instruction RAM write port and replaces free-running word loading with a flow-controlled, error-checked load.

---
 rtl/cpu_rv32_pkg.sv | 28 ++
 rtl/instr_loader_word_packer.sv | 38 +++
 rtl/instr_loader.sv | 193 +++++++++++++++++++
 tb/tb_instr_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_rv32_pkg.sv
// Shared definitions for the program-download path: STOP word, loader states, error codes.
// LOADER_CHECKSUM_EN adds the CHECK state used by the trailing checksum byte.
package cpu_rv32_pkg;

    localparam logic [31:0] STOP_WORD = 32'h007F_007F;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } loader_state_e;

    // Running 8-bit stream checksum; wraps modulo 256.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/instr_loader_word_packer.sv
// Assembles four accepted bytes into a little-endian word and strobes on the fourth byte.
module word_packer
    import cpu_rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  idx_r;
    logic [23:0] shift_r;

    // The incoming byte completes the word in the same cycle it is accepted.
    assign word      = {byte_in, shift_r};
    assign word_done = accept && (idx_r == 2'd3);

    // Byte index and shift register; newest byte enters at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r   <= 2'd0;
            shift_r <= 24'd0;
        end else if (clr) begin
            idx_r   <= 2'd0;
            shift_r <= 24'd0;
        end else if (accept) begin
            idx_r   <= idx_r + 2'd1;
            shift_r <= {byte_in, shift_r[23:8]};
        end else begin
            idx_r   <= idx_r;
            shift_r <= shift_r;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Flow-controlled instruction RAM loader: bytes -> words -> RAM writes until STOP.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte after STOP.
module instr_loader
    import cpu_rv32_pkg::*;
#(
    parameter int unsigned MAX_WORDS   = 4096,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_flag,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        load_done,
    output logic        load_err,
    output logic [1:0]  err_code,
    output logic [15:0] word_cnt
);

    localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [15:0]   MAX_W16  = 16'(MAX_WORDS);

    loader_state_e state_r;
    logic          byte_ready_r;
    logic          wr_en_r;
    logic [15:0]   wr_addr_r;
    logic [31:0]   wr_data_r;
    logic          busy_r;
    logic          load_done_r;
    logic          load_err_r;
    logic [1:0]    err_code_r;
    logic [15:0]   word_cnt_r;
    logic [TW-1:0] tmo_cnt_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_r;
`endif

    logic          accept_s;
    logic          pack_accept_s;
    logic          pack_clr_s;
    logic [31:0]   word_s;
    logic          word_done_s;

    assign accept_s      = byte_valid && byte_ready_r;
    assign pack_accept_s = accept_s && (state_r == ST_RECV);
    assign pack_clr_s    = (state_r == ST_IDLE) && start_flag;

    word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pack_clr_s),
        .accept    (pack_accept_s),
        .byte_in   (byte_data),
        .word      (word_s),
        .word_done (word_done_s)
    );

    // Loader FSM; every output is set one cycle ahead from the next-state decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            byte_ready_r <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= 16'd0;
            wr_data_r    <= 32'd0;
            busy_r       <= 1'b0;
            load_done_r  <= 1'b0;
            load_err_r   <= 1'b0;
            err_code_r   <= ERR_NONE;
            word_cnt_r   <= 16'd0;
            tmo_cnt_r    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_r       <= 8'd0;
`endif
        end else begin
            wr_en_r     <= 1'b0;
            load_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_flag) begin
                        word_cnt_r   <= 16'd0;
                        load_err_r   <= 1'b0;
                        err_code_r   <= ERR_NONE;
                        tmo_cnt_r    <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_r       <= 8'd0;
`endif
                        state_r      <= ST_RECV;
                        busy_r       <= 1'b1;
                        byte_ready_r <= 1'b1;
                    end else begin
                        busy_r       <= 1'b0;
                        byte_ready_r <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (accept_s) begin
                        tmo_cnt_r <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_r    <= csum_add(csum_r, byte_data);
`endif
                        if (word_done_s) begin
                            state_r      <= ST_WRITE;
                            byte_ready_r <= 1'b0;
                            wr_en_r      <= 1'b1;
                            wr_addr_r    <= {word_cnt_r[13:0], 2'b00};
                            wr_data_r    <= word_s;
                        end else begin
                            state_r <= ST_RECV;
                        end
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        state_r      <= ST_ERR;
                        byte_ready_r <= 1'b0;
                        err_code_r   <= ERR_TIMEOUT;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end
                ST_WRITE: begin
                    word_cnt_r <= word_cnt_r + 16'd1;
                    tmo_cnt_r  <= '0;
                    if (wr_data_r == STOP_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                        state_r      <= ST_CHECK;
                        byte_ready_r <= 1'b1;
`else
                        state_r      <= ST_DONE;
                        load_done_r  <= 1'b1;
`endif
                    end else if ((word_cnt_r + 16'd1) == MAX_W16) begin
                        state_r    <= ST_ERR;
                        err_code_r <= ERR_OVERFLOW;
                    end else begin
                        state_r      <= ST_RECV;
                        byte_ready_r <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept_s) begin
                        byte_ready_r <= 1'b0;
                        csum_r       <= csum_add(csum_r, byte_data);
                        if (csum_add(csum_r, byte_data) == 8'd0) begin
                            state_r     <= ST_DONE;
                            load_done_r <= 1'b1;
                        end else begin
                            state_r    <= ST_ERR;
                            err_code_r <= ERR_CHECKSUM;
                        end
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        state_r      <= ST_ERR;
                        byte_ready_r <= 1'b0;
                        err_code_r   <= ERR_TIMEOUT;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                ST_ERR: begin
                    load_err_r <= 1'b1;
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    byte_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign busy       = busy_r;
    assign load_done  = load_done_r;
    assign load_err   = load_err_r;
    assign err_code   = err_code_r;
    assign word_cnt   = word_cnt_r;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader against a stream-level reference model.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_instr_loader;

    localparam int MAXW = 4;
    localparam int TMO  = 16;
    localparam logic [31:0] STOP = 32'h007F007F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_flag = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready, wr_en, busy, load_done, load_err;
    logic [15:0] wr_addr, word_cnt;
    logic [31:0] wr_data;
    logic [1:0]  err_code;

    int checks_n = 0;
    int fail_n   = 0;

    logic [7:0]  stream_q[$];
    logic [47:0] got_q[$];
    logic [47:0] exp_q[$];
    int          done_cnt = 0;
    int          overlap_cnt = 0;

    instr_loader #(.MAX_WORDS(MAXW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start_flag(start_flag),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .load_done(load_done), .load_err(load_err), .err_code(err_code),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Record RAM writes and completion pulses as seen mid-cycle.
    always @(negedge clk) begin
        if (wr_en) got_q.push_back({wr_addr, wr_data});
        if (load_done) done_cnt++;
        if (wr_en && byte_ready) overlap_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_n++;
        if (got !== exp) begin
            fail_n++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: what a correct loader does with the whole byte stream.
    task automatic model(output int exp_err, output int exp_done);
        int p; int w; int sum; logic [31:0] word;
        exp_q.delete();
        exp_err = 0; exp_done = 0; p = 0; w = 0; sum = 0;
        forever begin
            if (p + 4 > stream_q.size()) begin exp_err = 1; break; end
            word = {stream_q[p+3], stream_q[p+2], stream_q[p+1], stream_q[p]};
            sum = sum + stream_q[p] + stream_q[p+1] + stream_q[p+2] + stream_q[p+3];
            exp_q.push_back({16'(w * 4), word});
            p += 4; w++;
            if (word == STOP) begin
`ifdef LOADER_CHECKSUM_EN
                if (p >= stream_q.size()) exp_err = 1;
                else if (((sum + stream_q[p]) % 256) == 0) exp_done = 1;
                else exp_err = 3;
`else
                exp_done = 1;
`endif
                break;
            end
            if (w == MAXW) begin exp_err = 2; break; end
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] v;
        v = $urandom();
        if (v == STOP) v = 32'h00000013;
        return v;
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) stream_q.push_back(8'((w >> (8 * k)) & 32'hFF));
    endtask

    // Feed stream_q; mode 0 steady, 1 drops every third cycle, 2 random drops.
    task automatic send_stream(input int mode);
        int i; int cyc;
        i = 0; cyc = 0;
        while (i < stream_q.size() && cyc < 400) begin
            @(negedge clk);
            cyc++;
            case (mode)
                1: byte_valid = ((cyc % 3) != 0);
                2: byte_valid = ($urandom_range(0, 99) >= 30);
                default: byte_valid = 1'b1;
            endcase
            byte_data = stream_q[i];
            if (byte_valid && byte_ready) i++;
        end
        chk("send_budget", (cyc < 400), 1'b1);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom());
    endtask

    task automatic start_load(input string tag);
        got_q.delete(); done_cnt = 0; overlap_cnt = 0;
        @(negedge clk);
        start_flag = 1'b1;
        @(negedge clk);
        start_flag = 1'b0;
        chk({tag, "_busy_n1"}, busy, 1'b1);
        chk({tag, "_ready_n1"}, byte_ready, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int b;
        b = 0;
        while (busy && b < 300) begin @(negedge clk); b++; end
        chk({tag, "_idle_budget"}, (b < 300), 1'b1);
        @(negedge clk);
    endtask

    task automatic run_and_check(input string tag, input int mode);
        int e_err; int e_done;
        model(e_err, e_done);
        start_load(tag);
        send_stream(mode);
        wait_idle(tag);
        chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk({tag, "_write"}, got_q[k], exp_q[k]);
        chk({tag, "_word_cnt"}, word_cnt, exp_q.size());
        chk({tag, "_done"}, done_cnt, e_done);
        chk({tag, "_load_err"}, load_err, (e_err != 0));
        chk({tag, "_err_code"}, err_code, e_err);
        chk({tag, "_ready_in_write"}, overlap_cnt, 0);
    endtask

    initial begin
        int k; int sum;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", byte_ready, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_outs", {wr_addr, wr_data, word_cnt, err_code, load_err, load_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed three-word program, steady then with periodic gaps.
        stream_q.delete();
        push_word(32'h00000013); push_word(32'h00100093); push_word(STOP);
`ifdef LOADER_CHECKSUM_EN
        sum = 0;
        foreach (stream_q[i]) sum += stream_q[i];
        stream_q.push_back(8'((256 - (sum % 256)) % 256));
`endif
        run_and_check("basic", 0);
        run_and_check("gaps", 1);

        // Four plain words overflow the RAM.
        stream_q.delete();
        for (int i = 0; i < MAXW; i++) push_word(rand_word());
        run_and_check("overflow", 0);

        // Stream stalls mid-word: timeout counted from the last accepted byte.
        stream_q.delete();
        stream_q.push_back(8'h13); stream_q.push_back(8'h00);
        start_load("tmo");
        send_stream(0);
        k = 1;
        while (err_code != 2'd1 && k < 100) begin @(negedge clk); k++; end
        chk("tmo_latency", k, 17);
        wait_idle("tmo");
        chk("tmo_no_write", got_q.size(), 0);
        chk("tmo_load_err", load_err, 1'b1);
        chk("tmo_code", err_code, 2'd1);

`ifdef LOADER_CHECKSUM_EN
        stream_q.delete();
        push_word(STOP); stream_q.push_back(8'h02);
        run_and_check("csum_ok", 0);
        chk("csum_ok_code", err_code, 2'd0);
        stream_q.delete();
        push_word(STOP); stream_q.push_back(8'h03);
        run_and_check("csum_bad", 0);
        chk("csum_bad_code", err_code, 2'd3);
`endif

        // Reset in the middle of a word, then a clean one-word load.
        stream_q.delete();
        stream_q.push_back(8'hAA); stream_q.push_back(8'hBB);
        start_load("rst");
        send_stream(0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_ready", byte_ready, 1'b0);
        chk("rst_mid_cnt", word_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stream_q.delete();
        push_word(STOP);
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(8'h02);
`endif
        run_and_check("after_rst", 0);

        // Random programs: up to three words then STOP, or an overflowing run.
        for (int t = 0; t < 12; t++) begin
            stream_q.delete();
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < MAXW; i++) push_word(rand_word());
            end else begin
                k = $urandom_range(0, MAXW - 1);
                for (int i = 0; i < k; i++) push_word(rand_word());
                push_word(STOP);
`ifdef LOADER_CHECKSUM_EN
                sum = 0;
                foreach (stream_q[i]) sum += stream_q[i];
                if ($urandom_range(0, 1) == 0) stream_q.push_back(8'((256 - (sum % 256)) % 256));
                else stream_q.push_back(8'((257 - (sum % 256)) % 256));
`endif
            end
            run_and_check("rand", $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
        $finish;
    end

endmodule
